// File: rtl/key_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_cond_pkg
// Description : Shared constants and helpers for the key conditioner array.
// Revision    : 1.0 - initial release
// ============================================================================
package key_cond_pkg;

  localparam logic PRESS   = 1'b1;
  localparam logic RELEASE = 1'b0;

  // Minimum index width needed to address n channels (never below 1).
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    for (int k = 1; k < 6; k++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce_chan.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_chan
// Description : One key channel: synchroniser, debounce counter, edge pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_chan
  import key_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNTW        = 3,
  parameter int WAITTIME    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_noisy,
  output logic o_conditioned,
  output logic o_pos,
  output logic o_neg
);

  localparam logic [CNTW-1:0] c_wait = CNTW'(WAITTIME);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNTW-1:0]        r_cnt;
  logic                   r_cond;
  logic                   r_pos;
  logic                   r_neg;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_cond <= 1'b0;
      r_pos  <= 1'b0;
      r_neg  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_noisy};
      r_pos  <= 1'b0;
      r_neg  <= 1'b0;
      if (w_s == r_cond) begin
        r_cnt <= '0;
      end else if (r_cnt == c_wait) begin
        // Level and its edge pulse become visible on the same clock.
        r_cond <= w_s;
        r_cnt  <= '0;
        r_pos  <= w_s;
        r_neg  <= ~w_s;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_conditioned = r_cond;
  assign o_pos         = r_pos;
  assign o_neg         = r_neg;

endmodule
`default_nettype wire

// File: rtl/key_conditioner_array.sv
`default_nettype none
// ============================================================================
// Module      : key_conditioner_array
// Description : NCHAN debounced key inputs merged into one valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module key_conditioner_array
  import key_cond_pkg::*;
#(
  parameter int NCHAN       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNTW        = 3,
  parameter int WAITTIME    = 3,
  parameter int IDXW        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCHAN-1:0] noisy,
  output logic [NCHAN-1:0] conditioned,
  output logic [NCHAN-1:0] posedge_pulse,
  output logic [NCHAN-1:0] negedge_pulse,
  output logic             event_valid,
  input  logic             event_ready,
  output logic [IDXW-1:0]  event_key,
  output logic             event_press,
  output logic [NCHAN-1:0] overrun,
  input  logic             overrun_clr
);

  logic [NCHAN-1:0] r_pend;
  logic [NCHAN-1:0] r_dir;
  logic [NCHAN-1:0] r_ovr;
  logic             r_valid;
  logic [IDXW-1:0]  r_key;
  logic             r_press;

  logic [NCHAN-1:0] w_edge;
  logic [NCHAN-1:0] w_grant;
  logic [NCHAN-1:0] w_clear;
  logic [NCHAN-1:0] w_pend_next;
  logic [NCHAN-1:0] w_dir_next;
  logic [NCHAN-1:0] w_ovr_next;
  logic             w_load;
  logic             w_any;
  logic [IDXW-1:0]  w_sel;
  logic             w_sel_dir;

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    key_debounce_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNTW        (CNTW),
      .WAITTIME    (WAITTIME)
    ) u_chan (
      .clk           (clk),
      .rst           (reset),
      .i_noisy       (noisy[g]),
      .o_conditioned (conditioned[g]),
      .o_pos         (posedge_pulse[g]),
      .o_neg         (negedge_pulse[g])
    );
  end

  // Lowest-index pending channel wins.
  always_comb begin
    w_any     = 1'b0;
    w_sel     = '0;
    w_sel_dir = 1'b0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_any     = 1'b1;
        w_sel     = IDXW'(i);
        w_sel_dir = r_dir[i];
      end
    end
  end

  assign w_load  = ~r_valid | event_ready;
  assign w_edge  = posedge_pulse | negedge_pulse;
  assign w_grant = r_pend & (~r_pend + NCHAN'(1));
  assign w_clear = w_load ? w_grant : '0;

  // A new edge on the channel being unloaded re-arms it without an overrun.
  always_comb begin
    w_pend_next = (r_pend & ~w_clear) | w_edge;
    w_ovr_next  = (overrun_clr ? '0 : r_ovr) | (w_edge & r_pend & ~w_clear);
    w_dir_next  = r_dir;
    for (int i = 0; i < NCHAN; i++) begin
      if (w_edge[i]) w_dir_next[i] = posedge_pulse[i] ? PRESS : RELEASE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend  <= '0;
      r_dir   <= '0;
      r_ovr   <= '0;
      r_valid <= 1'b0;
      r_key   <= '0;
      r_press <= 1'b0;
    end else begin
      r_pend <= w_pend_next;
      r_dir  <= w_dir_next;
      r_ovr  <= w_ovr_next;
      if (w_load) begin
        r_valid <= w_any;
        if (w_any) begin
          r_key   <= w_sel;
          r_press <= w_sel_dir;
        end
      end
    end
  end

  assign event_valid = r_valid;
  assign event_key   = r_key;
  assign event_press = r_press;
  assign overrun     = r_ovr;

endmodule
`default_nettype wire
